// File: rtl/dec_crc_seq.sv
// dec_crc_seq -- sequencer between the frame source and a chunk-serial CRC
// engine in the DEC path.
//
// One frame (payload + received checksum) is accepted, streamed to the engine
// CHUNK_WIDTH bits per cycle (chunk 0 = payload LSBs), the engine CRC is
// awaited (bounded by TIMEOUT cycles), compared against the received checksum,
// and a pass/fail result is returned. Saturating frame/error counters track
// delivered results.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer holds valid and its payload stable until that edge;
// ready never depends on valid. Input side: valid_i/ready_o (ready_o=1 only in
// IDLE). Output side: valid_o/ready_i (valid_o=1 only in RESP, result fields
// stable while waiting).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   valid_i, ready_o           input frame handshake
//   data_i, checksum_i         received payload and checksum
//   eng_init_o                 one-cycle engine accumulator clear
//   eng_valid_o, eng_data_o    payload chunk to the engine
//   eng_last_o                 current chunk is the final one
//   eng_done_i, eng_crc_i      engine result (sampled only in WAIT)
//   valid_o, ready_i           result handshake
//   crc_ok_o, timeout_o        result flags
//   crc_calc_o                 captured engine CRC (0 on timeout)
//   frm_cnt_o, err_cnt_o       saturating delivered / failed result counters
//
// The FSM state is held in the signal `state` for checker binding.

module dec_crc_seq #(
  parameter int DATA_WIDTH  = 512,
  parameter int CRC_WIDTH   = 32,
  parameter int CHUNK_WIDTH = 64,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [CRC_WIDTH-1:0]   checksum_i,
  output logic                   eng_init_o,
  output logic                   eng_valid_o,
  output logic [CHUNK_WIDTH-1:0] eng_data_o,
  output logic                   eng_last_o,
  input  logic                   eng_done_i,
  input  logic [CRC_WIDTH-1:0]   eng_crc_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   crc_ok_o,
  output logic                   timeout_o,
  output logic [CRC_WIDTH-1:0]   crc_calc_o,
  output logic [15:0]            frm_cnt_o,
  output logic [15:0]            err_cnt_o
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int TMR_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_FEED = 3'd2,
    S_WAIT = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0]  data_q;
  logic [CRC_WIDTH-1:0]   chk_q;
  logic [IDX_W-1:0]       idx_q, idx_n;
  logic [TMR_W-1:0]       tmr_q, tmr_n;

  logic                   crc_ok_q, crc_ok_n;
  logic                   timeout_q, timeout_n;
  logic [CRC_WIDTH-1:0]   crc_calc_q, crc_calc_n;
  logic [15:0]            frm_cnt_q, err_cnt_q;

  logic                   eng_init_q, eng_valid_q, eng_last_q;
  logic [CHUNK_WIDTH-1:0] eng_data_q;
  logic                   eng_init_n, eng_valid_n, eng_last_n;
  logic [CHUNK_WIDTH-1:0] eng_data_n;

  logic                   capture;
  logic                   res_hs;

  // Next-state / next-value logic
  always_comb begin
    state_n    = state;
    idx_n      = idx_q;
    tmr_n      = tmr_q;
    crc_ok_n   = crc_ok_q;
    timeout_n  = timeout_q;
    crc_calc_n = crc_calc_q;
    capture    = 1'b0;
    res_hs     = 1'b0;

    case (state)
      S_IDLE: begin
        if (valid_i) begin
          capture = 1'b1;
          state_n = S_INIT;
        end
      end
      S_INIT: begin
        idx_n   = '0;
        tmr_n   = '0;
        state_n = S_FEED;
      end
      S_FEED: begin
        if (idx_q == LAST_IDX) begin
          state_n = S_WAIT;
        end else begin
          idx_n = idx_q + 1'b1;
        end
      end
      S_WAIT: begin
        tmr_n = tmr_q + 1'b1;
        // A real engine result wins over a timeout in the same cycle.
        if (eng_done_i) begin
          crc_ok_n   = (eng_crc_i == chk_q);
          timeout_n  = 1'b0;
          crc_calc_n = eng_crc_i;
          state_n    = S_RESP;
        end else if (tmr_q == TMR_LAST) begin
          crc_ok_n   = 1'b0;
          timeout_n  = 1'b1;
          crc_calc_n = '0;
          state_n    = S_RESP;
        end
      end
      S_RESP: begin
        if (ready_i) begin
          res_hs  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Engine outputs are registered, so they are derived from the next state
  // and next chunk index; they then line up with `state`/`idx_q` each cycle.
  always_comb begin
    eng_init_n  = (state_n == S_INIT);
    eng_valid_n = (state_n == S_FEED);
    eng_last_n  = (state_n == S_FEED) && (idx_n == LAST_IDX);
    eng_data_n  = '0;
    if (state_n == S_FEED) begin
      eng_data_n = data_q[int'(idx_n) * CHUNK_WIDTH +: CHUNK_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      data_q      <= '0;
      chk_q       <= '0;
      idx_q       <= '0;
      tmr_q       <= '0;
      crc_ok_q    <= 1'b0;
      timeout_q   <= 1'b0;
      crc_calc_q  <= '0;
      frm_cnt_q   <= '0;
      err_cnt_q   <= '0;
      eng_init_q  <= 1'b0;
      eng_valid_q <= 1'b0;
      eng_last_q  <= 1'b0;
      eng_data_q  <= '0;
    end else begin
      state       <= state_n;
      idx_q       <= idx_n;
      tmr_q       <= tmr_n;
      crc_ok_q    <= crc_ok_n;
      timeout_q   <= timeout_n;
      crc_calc_q  <= crc_calc_n;
      eng_init_q  <= eng_init_n;
      eng_valid_q <= eng_valid_n;
      eng_last_q  <= eng_last_n;
      eng_data_q  <= eng_data_n;
      if (capture) begin
        data_q <= data_i;
        chk_q  <= checksum_i;
      end
      if (res_hs) begin
        if (frm_cnt_q != 16'hFFFF) frm_cnt_q <= frm_cnt_q + 16'd1;
        if (!crc_ok_q && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign ready_o     = (state == S_IDLE);
  assign valid_o     = (state == S_RESP);
  assign crc_ok_o    = crc_ok_q;
  assign timeout_o   = timeout_q;
  assign crc_calc_o  = crc_calc_q;
  assign frm_cnt_o   = frm_cnt_q;
  assign err_cnt_o   = err_cnt_q;
  assign eng_init_o  = eng_init_q;
  assign eng_valid_o = eng_valid_q;
  assign eng_data_o  = eng_data_q;
  assign eng_last_o  = eng_last_q;

endmodule

// File: tb/tb_dec_crc_seq.sv
// tb_dec_crc_seq -- directed bench for dec_crc_seq (default parameters).
// A behavioural CRC-32 engine answers the DUT's chunk stream; expected values
// come from the same CRC model applied directly to the frame payload.

module tb_dec_crc_seq;

  localparam int DW  = 512;
  localparam int CW  = 32;
  localparam int KW  = 64;
  localparam int NCH = DW / KW;
  localparam int TO  = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [DW-1:0] data_i = '0;
  logic [CW-1:0] checksum_i = '0;
  logic          eng_init_o;
  logic          eng_valid_o;
  logic [KW-1:0] eng_data_o;
  logic          eng_last_o;
  logic          eng_done_i = 1'b0;
  logic [CW-1:0] eng_crc_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic          crc_ok_o;
  logic          timeout_o;
  logic [CW-1:0] crc_calc_o;
  logic [15:0]   frm_cnt_o;
  logic [15:0]   err_cnt_o;

  always #5 clk = ~clk;

  dec_crc_seq #(.DATA_WIDTH(DW), .CRC_WIDTH(CW), .CHUNK_WIDTH(KW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .checksum_i(checksum_i),
    .eng_init_o(eng_init_o), .eng_valid_o(eng_valid_o), .eng_data_o(eng_data_o),
    .eng_last_o(eng_last_o), .eng_done_i(eng_done_i), .eng_crc_i(eng_crc_i),
    .valid_o(valid_o), .ready_i(ready_i), .crc_ok_o(crc_ok_o), .timeout_o(timeout_o),
    .crc_calc_o(crc_calc_o), .frm_cnt_o(frm_cnt_o), .err_cnt_o(err_cnt_o)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, req, $time);
    end
  endtask

  // ---------------- CRC model ----------------
  function automatic logic [31:0] crc_chunk(input logic [31:0] c, input logic [63:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 64; i++) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C1_1DB7;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_crc(input logic [DW-1:0] d);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < NCH; k++) c = crc_chunk(c, d[k*KW +: KW]);
    return c;
  endfunction

  // ---------------- engine model ----------------
  bit            eng_en = 1'b1;      // 0: engine never answers
  logic          force_done = 1'b0;  // stray done pulses outside WAIT
  logic [CW-1:0] force_crc = '0;
  logic          pend = 1'b0;
  logic [CW-1:0] acc = '1;
  int            beat = 0;
  logic [DW-1:0] exp_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend       = 1'b0;
      beat       = 0;
      eng_done_i = 1'b0;
      eng_crc_i  = '0;
    end else begin
      eng_done_i = pend | force_done;
      eng_crc_i  = pend ? acc : (force_done ? force_crc : '0);
      pend       = 1'b0;
      if (eng_init_o) begin
        acc  = 32'hFFFF_FFFF;
        beat = 0;
      end
      if (eng_valid_o) begin
        if (beat < NCH) begin
          check("chunk", eng_data_o, exp_data[beat*KW +: KW]);
          check("eng_last", 64'(eng_last_o), 64'(beat == NCH - 1));
        end else begin
          check("beat_overrun", 64'(beat), 64'(NCH - 1));
        end
        acc = crc_chunk(acc, eng_data_o);
        beat++;
        if (eng_last_o && eng_en) pend = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present a frame and return just after the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c);
    int n;
    @(negedge clk);
    exp_data   = d;
    data_i     = d;
    checksum_i = c;
    valid_i    = 1'b1;
    n = 0;
    while (!ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  // Count cycles from the accepting edge until valid_o; ends on a negedge.
  task automatic wait_result(input int lat_req, input bit chk_init);
    int got;
    got = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (chk_init && n == 1) check("init_pulse", 64'(eng_init_o), 64'd1);
      if (chk_init && n == 2) begin
        check("init_single", 64'(eng_init_o), 64'd0);
        check("feed_start", 64'(eng_valid_o), 64'd1);
      end
      if (valid_o) begin
        got = n;
        break;
      end
    end
    check("latency", 64'(got), 64'(lat_req));
  endtask

  // Called on a negedge in RESP; completes the result handshake.
  task automatic take();
    ready_i = 1'b1;
    @(posedge clk);
    #1 ready_i = 1'b0;
  endtask

  task automatic check_cnt(input logic [15:0] frm, input logic [15:0] err);
    check("frm_cnt", 64'(frm_cnt_o), 64'(frm));
    check("err_cnt", 64'(err_cnt_o), 64'(err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] d1, d3;
  logic [CW-1:0] c1, c2, c3;

  initial begin
    for (int b = 0; b < DW / 8; b++) d1[b*8 +: 8] = 8'(b);
    for (int i = 0; i < DW / 32; i++) d3[i*32 +: 32] = 32'hDEAD_0000 + 32'(i) * 32'h1111;
    c1 = model_crc(d1);
    c2 = c1 ^ 32'h0000_0020;
    c3 = model_crc(d3);

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_init", 64'(eng_init_o), 64'd0);
    check("rst_eng_valid", 64'(eng_valid_o), 64'd0);
    check("rst_eng_last", 64'(eng_last_o), 64'd0);
    check("rst_eng_data", eng_data_o, 64'd0);
    check("rst_crc_ok", 64'(crc_ok_o), 64'd0);
    check("rst_timeout", 64'(timeout_o), 64'd0);
    check("rst_crc_calc", 64'(crc_calc_o), 64'd0);
    check_cnt(16'd0, 16'd0);
    rst_n = 1'b1;

    // Clean frame
    send(d1, c1);
    wait_result(NCH + 3, 1'b1);
    check("beats", 64'(beat), 64'(NCH));
    check("clean_ok", 64'(crc_ok_o), 64'd1);
    check("clean_to", 64'(timeout_o), 64'd0);
    check("clean_calc", 64'(crc_calc_o), 64'(c1));
    take();
    @(negedge clk);
    check("clean_valid_fall", 64'(valid_o), 64'd0);
    check("clean_ready", 64'(ready_o), 64'd1);
    check_cnt(16'd1, 16'd0);

    // Corrupted checksum (bit 5 flipped)
    send(d1, c2);
    wait_result(NCH + 3, 1'b0);
    check("bad_ok", 64'(crc_ok_o), 64'd0);
    check("bad_to", 64'(timeout_o), 64'd0);
    check("bad_calc", 64'(crc_calc_o), 64'(c1));
    take();
    @(negedge clk);
    check_cnt(16'd2, 16'd1);

    // Backpressure: 10 cycles with ready_i=0 while another frame waits
    send(d3, c3);
    wait_result(NCH + 3, 1'b0);
    data_i  = '1;
    valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 64'(valid_o), 64'd1);
      check("bp_ready", 64'(ready_o), 64'd0);
      check("bp_ok", 64'(crc_ok_o), 64'd1);
      check("bp_to", 64'(timeout_o), 64'd0);
      check("bp_calc", 64'(crc_calc_o), 64'(c3));
      check_cnt(16'd2, 16'd1);
      @(negedge clk);
    end
    valid_i = 1'b0;
    take();
    @(negedge clk);
    check("bp_after_ready", 64'(ready_o), 64'd1);
    check_cnt(16'd3, 16'd1);

    // Timeout: engine silent, stray done pulses in RESP and IDLE ignored
    eng_en = 1'b0;
    send(d1, c1);
    wait_result(NCH + 2 + TO, 1'b0);
    check("to_flag", 64'(timeout_o), 64'd1);
    check("to_ok", 64'(crc_ok_o), 64'd0);
    check("to_calc", 64'(crc_calc_o), 64'd0);
    force_done = 1'b1;
    force_crc  = c1;
    repeat (3) begin
      @(negedge clk);
      check("late_resp_valid", 64'(valid_o), 64'd1);
      check("late_resp_to", 64'(timeout_o), 64'd1);
      check("late_resp_calc", 64'(crc_calc_o), 64'd0);
    end
    force_done = 1'b0;
    @(negedge clk);
    take();
    @(negedge clk);
    check_cnt(16'd4, 16'd2);
    force_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("late_idle_ready", 64'(ready_o), 64'd1);
      check("late_idle_valid", 64'(valid_o), 64'd0);
      check("late_idle_eng", 64'(eng_valid_o), 64'd0);
    end
    force_done = 1'b0;
    eng_en     = 1'b1;
    repeat (2) @(negedge clk);

    // Reset during FEED beat 4, then a normal frame
    send(d3, c3);
    repeat (5) @(negedge clk);
    check("mid_feed_valid", 64'(eng_valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_eng_valid", 64'(eng_valid_o), 64'd0);
    check("arst_valid", 64'(valid_o), 64'd0);
    check("arst_ready", 64'(ready_o), 64'd1);
    check_cnt(16'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(d1, c1);
    wait_result(NCH + 3, 1'b1);
    check("post_rst_ok", 64'(crc_ok_o), 64'd1);
    check("post_rst_calc", 64'(crc_calc_o), 64'(c1));
    take();
    @(negedge clk);
    check_cnt(16'd1, 16'd0);

    // Saturation: preload counters near the top, then two failing frames
    force dut.frm_cnt_q = 16'hFFFE;
    force dut.err_cnt_q = 16'hFFFE;
    #1;
    release dut.frm_cnt_q;
    release dut.err_cnt_q;
    @(negedge clk);
    check_cnt(16'hFFFE, 16'hFFFE);
    send(d1, c2);
    wait_result(NCH + 3, 1'b0);
    take();
    @(negedge clk);
    check_cnt(16'hFFFF, 16'hFFFF);
    send(d1, c2);
    wait_result(NCH + 3, 1'b0);
    take();
    @(negedge clk);
    check_cnt(16'hFFFF, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
